fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, the address fetched first after reset.
REQ-002 clk  input  1  rising-edge clock; sole clock domain.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 imem_address  output  16  instruction memory read address (lc3b_word).
REQ-005 imem_read  output  1  instruction memory read request.
REQ-006 imem_rdata  input  16  instruction word; valid only when imem_resp=1.
REQ-007 imem_resp  input  1  memory completion strobe for the current request.
REQ-008 stall  input  1  downstream IF/ID cannot load this cycle.
REQ-009 redirect  input  1  taken branch/jump; fetch restarts at redirect_pc.
REQ-010 redirect_pc  input  16  redirect target address.
REQ-011 if_pc  output  16  address of the presented instruction.
REQ-012 if_instruction  output  16  presented instruction word.
REQ-013 if_valid  output  1  if_pc/if_instruction hold a live bundle.

Function
REQ-014 The FSM SHALL have states FETCH, SQUASH, HOLD; registers pc, pending_pc, if_pc, if_instruction, if_valid.
REQ-015 imem_read SHALL be 1 in FETCH and SQUASH, 0 in HOLD; imem_address SHALL equal pc in every state.
REQ-016 pc and imem_address SHALL stay constant while imem_read=1 until imem_resp=1; a request is never abandoned.
REQ-017 FETCH, imem_resp=1, redirect=0: if_pc<=pc, if_instruction<=imem_rdata, if_valid<=1, pc<=pc+2, next HOLD.
REQ-018 HOLD, redirect=0, stall=0: bundle consumed at this edge; if_valid<=0, next FETCH.
REQ-019 HOLD, redirect=0, stall=1: all outputs and pc held, stay HOLD.
REQ-020 FETCH, redirect=1, imem_resp=0: pending_pc<=redirect_pc, next SQUASH; pc unchanged.
REQ-021 FETCH, redirect=1, imem_resp=1: imem_rdata discarded, pc<=redirect_pc, if_valid stays 0, stay FETCH.
REQ-022 SQUASH, imem_resp=0: a further redirect SHALL overwrite pending_pc; otherwise hold.
REQ-023 SQUASH, imem_resp=1: imem_rdata discarded; pc<=(redirect ? redirect_pc : pending_pc); next FETCH.
REQ-024 HOLD, redirect=1: bundle dropped regardless of stall; if_valid<=0, pc<=redirect_pc, next FETCH.
REQ-025 Redirect SHALL take priority over stall and over imem_resp data capture in all states.
REQ-026 pc+2 SHALL wrap modulo 2^16 (16'hFFFE -> 16'h0000); bit 0 of redirect_pc SHALL be forced to 0.
REQ-027 Latency: imem_resp at edge N gives if_valid=1 after edge N; earliest new imem_read=1 follows consumption edge N+1.
REQ-028 if_valid SHALL never be 1 for an instruction fetched from an address squashed by a redirect.
REQ-029 imem_resp outside FETCH/SQUASH SHALL be ignored.

Reset
REQ-030 While reset=0: state=FETCH, pc=RESET_PC, pending_pc=0, if_pc=0, if_instruction=16'h0000 (NOP), if_valid=0, imem_read=0.
REQ-031 Reset assertion SHALL take effect immediately, mid-request included; any outstanding memory response is not tracked.
REQ-032 On the first rising clk with reset=1, imem_read=1 with imem_address=RESET_PC.

Verification
REQ-033 Release reset, resp after 2 cycles with rdata=16'h1234 -> if_pc=0000, if_instruction=1234, if_valid=1, next imem_address=0002.
REQ-034 Bundle valid, stall=1 for 3 cycles -> outputs stable, imem_read=0; stall=0 -> consumed, imem_read=1 next cycle.
REQ-035 Redirect to 16'h0041 during outstanding read of 0004, resp 2 cycles later -> data dropped, if_valid=0, next imem_address=0040.
REQ-036 Redirect to 0100 in HOLD with stall=1 -> if_valid=0 next cycle, imem_address=0100.
REQ-037 pc=FFFE, resp -> if_pc=FFFE, next imem_address=0000.
REQ-038 reset=0 asserted mid-FETCH and mid-HOLD -> all outputs at REQ-030 values immediately, without clk.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch stage bus: instruction memory request/response, pipeline control
// from downstream (stall/redirect) and the IF/ID bundle presented downstream.
interface fetch_stage_if;
  logic [15:0] imem_address;
  logic        imem_read;
  logic [15:0] imem_rdata;
  logic        imem_resp;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] if_pc;
  logic [15:0] if_instruction;
  logic        if_valid;

  // Fetch stage side
  modport master (
    output imem_address, imem_read, if_pc, if_instruction, if_valid,
    input  imem_rdata, imem_resp, stall, redirect, redirect_pc
  );

  // Memory / pipeline side
  modport slave (
    input  imem_address, imem_read, if_pc, if_instruction, if_valid,
    output imem_rdata, imem_resp, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one memory read at a time, presents the
// returned word as an IF/ID bundle, and handles redirects without ever
// abandoning an outstanding memory request.
//
// state  | meaning
// FETCH  | read of pc outstanding; response becomes the next bundle
// SQUASH | read of pc outstanding but redirected; response is dropped
// HOLD   | bundle valid, waiting for downstream to consume it
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic          clk,
  input logic          reset,
  fetch_stage_if.master fe
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    SQUASH = 2'd1,
    HOLD   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] pending_pc_q, pending_pc_d;
  logic [15:0] if_pc_q, if_pc_d;
  logic [15:0] if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d;
  // Low from reset until the first clock edge, so no read is issued
  // (and no response is accepted) while reset is asserted.
  logic        started_q;

  logic [15:0] redirect_tgt;

  assign redirect_tgt      = {fe.redirect_pc[15:1], 1'b0};
  assign fe.imem_address   = pc_q;
  assign fe.imem_read      = started_q && (state_q != HOLD);
  assign fe.if_pc          = if_pc_q;
  assign fe.if_instruction = if_instr_q;
  assign fe.if_valid       = if_valid_q;

  // State and datapath registers with immediate asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      pending_pc_q <= 16'h0000;
      if_pc_q      <= 16'h0000;
      if_instr_q   <= 16'h0000;
      if_valid_q   <= 1'b0;
      started_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_pc_q <= pending_pc_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
      if_valid_q   <= if_valid_d;
      started_q    <= 1'b1;
    end
  end

  // Next-state logic; redirect always outranks stall and response capture.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pending_pc_d = pending_pc_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    if_valid_d   = if_valid_q;

    if (started_q) begin
      case (state_q)
        FETCH: begin
          if (fe.redirect) begin
            if (fe.imem_resp) begin
              pc_d = redirect_tgt;
            end else begin
              pending_pc_d = redirect_tgt;
              state_d      = SQUASH;
            end
          end else if (fe.imem_resp) begin
            if_pc_d    = pc_q;
            if_instr_d = fe.imem_rdata;
            if_valid_d = 1'b1;
            pc_d       = pc_q + 16'd2;
            state_d    = HOLD;
          end
        end
        SQUASH: begin
          if (fe.imem_resp) begin
            pc_d    = fe.redirect ? redirect_tgt : pending_pc_q;
            state_d = FETCH;
          end else if (fe.redirect) begin
            pending_pc_d = redirect_tgt;
          end
        end
        HOLD: begin
          if (fe.redirect) begin
            if_valid_d = 1'b0;
            pc_d       = redirect_tgt;
            state_d    = FETCH;
          end else if (!fe.stall) begin
            if_valid_d = 1'b0;
            state_d    = FETCH;
          end
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .reset (reset),
    .fe    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        resp;
    logic [15:0] rdata;
    logic [15:0] exp_addr;
    logic        exp_read;
    logic        exp_valid;
    logic [15:0] exp_pc;
    logic [15:0] exp_instr;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic st, logic rd, logic [15:0] rpc, logic rs,
                              logic [15:0] dat, logic [15:0] ea, logic er,
                              logic ev, logic [15:0] ep, logic [15:0] ei);
    vec_t v;
    v.stall = st; v.redirect = rd; v.redirect_pc = rpc; v.resp = rs;
    v.rdata = dat; v.exp_addr = ea; v.exp_read = er; v.exp_valid = ev;
    v.exp_pc = ep; v.exp_instr = ei;
    return v;
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(string tag, logic [15:0] ea, logic er, logic ev,
                            logic [15:0] ep, logic [15:0] ei);
    check({tag, ".addr"},  bus.imem_address, ea);
    check({tag, ".read"},  {15'd0, bus.imem_read}, {15'd0, er});
    check({tag, ".valid"}, {15'd0, bus.if_valid}, {15'd0, ev});
    check({tag, ".pc"},    bus.if_pc, ep);
    check({tag, ".instr"}, bus.if_instruction, ei);
  endtask

  task automatic drive(logic st, logic rd, logic [15:0] rpc, logic rs, logic [15:0] dat);
    bus.stall = st; bus.redirect = rd; bus.redirect_pc = rpc;
    bus.imem_resp = rs; bus.imem_rdata = dat;
  endtask

  task automatic step_vec(vec_t v, int idx);
    drive(v.stall, v.redirect, v.redirect_pc, v.resp, v.rdata);
    @(posedge clk);
    #1;
    check_outs($sformatf("vec%0d", idx), v.exp_addr, v.exp_read, v.exp_valid,
               v.exp_pc, v.exp_instr);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);

    // Columns: stall redirect redirect_pc resp rdata | addr read valid if_pc instr
    vq.push_back(mk(0,0,16'h0000,0,16'h0000, 16'h0000,1,0,16'h0000,16'h0000));
    vq.push_back(mk(0,0,16'h0000,0,16'h0000, 16'h0000,1,0,16'h0000,16'h0000));
    vq.push_back(mk(0,0,16'h0000,1,16'h1234, 16'h0002,0,1,16'h0000,16'h1234));
    vq.push_back(mk(1,0,16'h0000,0,16'h0000, 16'h0002,0,1,16'h0000,16'h1234));
    vq.push_back(mk(1,0,16'h0000,0,16'h0000, 16'h0002,0,1,16'h0000,16'h1234));
    vq.push_back(mk(1,0,16'h0000,0,16'h0000, 16'h0002,0,1,16'h0000,16'h1234));
    vq.push_back(mk(0,0,16'h0000,0,16'h0000, 16'h0002,1,0,16'h0000,16'h1234));
    vq.push_back(mk(0,0,16'h0000,1,16'h5678, 16'h0004,0,1,16'h0002,16'h5678));
    vq.push_back(mk(0,0,16'h0000,0,16'h0000, 16'h0004,1,0,16'h0002,16'h5678));
    // redirect to 0041 while read of 0004 outstanding
    vq.push_back(mk(0,1,16'h0041,0,16'h0000, 16'h0004,1,0,16'h0002,16'h5678));
    vq.push_back(mk(0,0,16'h0000,0,16'h0000, 16'h0004,1,0,16'h0002,16'h5678));
    vq.push_back(mk(0,0,16'h0000,1,16'hBEEF, 16'h0040,1,0,16'h0002,16'h5678));
    vq.push_back(mk(0,0,16'h0000,1,16'h1111, 16'h0042,0,1,16'h0040,16'h1111));
    // redirect in HOLD with stall
    vq.push_back(mk(1,1,16'h0100,0,16'h0000, 16'h0100,1,0,16'h0040,16'h1111));
    // redirect with response in FETCH: data dropped, stay FETCH
    vq.push_back(mk(0,1,16'h0200,1,16'hAAAA, 16'h0200,1,0,16'h0040,16'h1111));
    vq.push_back(mk(0,0,16'h0000,1,16'h2222, 16'h0202,0,1,16'h0200,16'h2222));
    // response in HOLD is ignored
    vq.push_back(mk(1,0,16'h0000,1,16'h9999, 16'h0202,0,1,16'h0200,16'h2222));
    vq.push_back(mk(0,0,16'h0000,0,16'h0000, 16'h0202,1,0,16'h0200,16'h2222));
    // SQUASH: pending overwritten by second redirect, then pending used
    vq.push_back(mk(0,1,16'hFFFF,0,16'h0000, 16'h0202,1,0,16'h0200,16'h2222));
    vq.push_back(mk(0,1,16'h0301,0,16'h0000, 16'h0202,1,0,16'h0200,16'h2222));
    vq.push_back(mk(0,0,16'h0000,1,16'hCCCC, 16'h0300,1,0,16'h0200,16'h2222));
    // wrap at FFFE
    vq.push_back(mk(0,1,16'hFFFF,1,16'h3333, 16'hFFFE,1,0,16'h0200,16'h2222));
    vq.push_back(mk(0,0,16'h0000,1,16'h4444, 16'h0000,0,1,16'hFFFE,16'h4444));
    vq.push_back(mk(0,0,16'h0000,0,16'h0000, 16'h0000,1,0,16'hFFFE,16'h4444));
    // SQUASH: redirect coincident with response wins over pending
    vq.push_back(mk(0,1,16'h0600,0,16'h0000, 16'h0000,1,0,16'hFFFE,16'h4444));
    vq.push_back(mk(0,1,16'h0700,1,16'hDDDD, 16'h0700,1,0,16'hFFFE,16'h4444));

    // Reset values, held over clocks with reset asserted
    #1;
    check_outs("reset0", 16'h0000, 0, 0, 16'h0000, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset_clk", 16'h0000, 0, 0, 16'h0000, 16'h0000);
    reset = 1'b1;
    #1;
    check("release.read", {15'd0, bus.imem_read}, 16'h0000);

    for (int i = 0; i < vq.size(); i++) step_vec(vq[i], i);

    // Asynchronous reset mid-FETCH (state FETCH, pc 0700)
    drive(0, 0, 16'h0000, 0, 16'h0000);
    #2 reset = 1'b0;
    #1;
    check_outs("arst_fetch", 16'h0000, 0, 0, 16'h0000, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_outs("rf_fetch", 16'h0000, 1, 0, 16'h0000, 16'h0000);
    drive(0, 0, 16'h0000, 1, 16'h7777);
    @(posedge clk); #1;
    check_outs("rf_hold", 16'h0002, 0, 1, 16'h0000, 16'h7777);

    // Asynchronous reset mid-HOLD
    drive(1, 0, 16'h0000, 0, 16'h0000);
    #2 reset = 1'b0;
    #1;
    check_outs("arst_hold", 16'h0000, 0, 0, 16'h0000, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 16'h0000, 0, 16'h0000);
    @(posedge clk); #1;
    check_outs("rf2_fetch", 16'h0000, 1, 0, 16'h0000, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
